// File: rtl/control_unit_fsm.sv
// control_unit_fsm: multi-cycle fetch/decode/execute controller with memory handshake and PC sequencing
module control_unit_fsm #(
  parameter int DATA_WIDTH      = 8,
  parameter int MUX_SELECT_BITS = 2,
  parameter int RF_ADDR_BITS    = 2,
  localparam int IW             = 4 + 2 * RF_ADDR_BITS + DATA_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       instr_req,
  output logic [DATA_WIDTH-1:0]      pc,
  input  logic                       instr_valid,
  input  logic [IW-1:0]              instr_data,
  output logic                       mem_req,
  output logic                       mem_we,
  output logic [DATA_WIDTH-1:0]      mem_addr,
  input  logic                       mem_ready,
  output logic [MUX_SELECT_BITS-1:0] mux_select,
  output logic [DATA_WIDTH-1:0]      imm_out,
  output logic [RF_ADDR_BITS-1:0]    rf_raddr,
  output logic [RF_ADDR_BITS-1:0]    rf_waddr,
  output logic                       rf_we,
  output logic                       halted,
  output logic                       illegal
);
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM_WAIT, HALT} state_t;
  localparam logic [3:0] OP_MOV = 4'h1;
  localparam logic [3:0] OP_LD  = 4'h2;
  localparam logic [3:0] OP_LDI = 4'h3;
  localparam logic [3:0] OP_ST  = 4'h4;
  localparam logic [3:0] OP_JMP = 4'h5;
  localparam logic [3:0] OP_HLT = 4'hF;
  state_t state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [IW-1:0] ir_q, ir_d;
  logic illegal_q, illegal_d;
  logic [3:0] op;
  logic [DATA_WIDTH-1:0] imm;
  logic is_mem;
  assign op        = ir_q[IW-1 -: 4];
  assign imm       = ir_q[DATA_WIDTH-1:0];
  assign is_mem    = op == OP_LD || op == OP_ST;
  assign rf_waddr  = ir_q[DATA_WIDTH+2*RF_ADDR_BITS-1 -: RF_ADDR_BITS];
  assign rf_raddr  = ir_q[DATA_WIDTH+RF_ADDR_BITS-1 -: RF_ADDR_BITS];
  assign imm_out   = imm;
  assign mem_addr  = imm;
  assign pc        = pc_q;
  assign illegal   = illegal_q;
  assign halted    = state_q == HALT;
  assign instr_req = state_q == FETCH;
  assign mem_req   = (state_q == EXEC && is_mem) || state_q == MEM_WAIT;
  assign mem_we    = mem_req && op == OP_ST;
  assign rf_we     = (state_q == EXEC && (op == OP_MOV || op == OP_LDI)) ||
                     (state_q == MEM_WAIT && op == OP_LD && mem_ready);
  assign mux_select = !rf_we ? '0 :
                      op == OP_LDI ? MUX_SELECT_BITS'(2) :
                      op == OP_LD  ? MUX_SELECT_BITS'(1) : '0;
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    illegal_d = illegal_q;
    case (state_q)
      FETCH: begin
        ir_d    = instr_valid ? instr_data : ir_q;
        state_d = instr_valid ? DECODE : FETCH;
      end
      DECODE: state_d = EXEC;
      EXEC: begin
        if (is_mem) state_d = MEM_WAIT;
        else if (op == OP_JMP) begin
          pc_d    = imm;
          state_d = FETCH;
        end else if (op == OP_HLT) state_d = HALT;
        else if (op > OP_JMP) begin
          illegal_d = 1'b1;
          state_d   = HALT;
        end else begin
          pc_d    = pc_q + DATA_WIDTH'(1);
          state_d = FETCH;
        end
      end
      MEM_WAIT: begin
        pc_d    = mem_ready ? pc_q + DATA_WIDTH'(1) : pc_q;
        state_d = mem_ready ? FETCH : MEM_WAIT;
      end
      default: state_d = HALT;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FETCH;
      pc_q      <= '0;
      ir_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      illegal_q <= illegal_d;
    end
  end
endmodule

// File: tb/tb_control_unit_fsm.sv
// tb_control_unit_fsm: randomized cycle-level checks of control_unit_fsm against an instruction-level model
module tb_control_unit_fsm;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic instr_req, instr_valid = 1'b0;
  logic [7:0] pc, mem_addr, imm_out;
  logic [15:0] instr_data = '0;
  logic mem_req, mem_we, mem_ready = 1'b0;
  logic [1:0] mux_select, rf_raddr, rf_waddr;
  logic rf_we, halted, illegal;
  int checks = 0;
  int errors = 0;
  logic [7:0] m_pc = '0;
  control_unit_fsm dut (
    .clk(clk), .rst(rst), .instr_req(instr_req), .pc(pc), .instr_valid(instr_valid),
    .instr_data(instr_data), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_ready(mem_ready), .mux_select(mux_select), .imm_out(imm_out), .rf_raddr(rf_raddr),
    .rf_waddr(rf_waddr), .rf_we(rf_we), .halted(halted), .illegal(illegal)
  );
  always #5 clk = ~clk;
  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    instr_valid = 1'b0;
    mem_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    m_pc = '0;
    #1;
    checks++;
    if (instr_req !== 1'b1 || pc !== 8'h00 || halted !== 1'b0 || illegal !== 1'b0 || rf_we !== 1'b0 ||
        mem_req !== 1'b0 || mem_we !== 1'b0 || mux_select !== 2'b00) begin
      errors++;
      $display("FAIL reset: req=%b pc=%h halted=%b illegal=%b rf_we=%b mem_req=%b mem_we=%b sel=%b, want req=1 pc=00 rest 0",
               instr_req, pc, halted, illegal, rf_we, mem_req, mem_we, mux_select);
    end
    @(negedge clk);
  endtask
  task automatic exec_instr(input logic [15:0] ins, input int stall, input int wait_n);
    logic [3:0] op;
    bit legal, is_mem, ends_halt;
    int we_cnt, exp_we_cnt;
    op = ins[15:12];
    legal = op inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'hF};
    is_mem = op == 4'h2 || op == 4'h4;
    ends_halt = !legal || op == 4'hF;
    exp_we_cnt = (op == 4'h1 || op == 4'h2 || op == 4'h3) ? 1 : 0;
    we_cnt = 0;
    for (int i = 0; i < stall; i++) begin
      instr_valid = 1'b0;
      instr_data = 16'($urandom);
      mem_ready = 1'($urandom);
      #1;
      checks++;
      if (instr_req !== 1'b1 || pc !== m_pc || rf_we !== 1'b0 || mem_req !== 1'b0) begin
        errors++;
        $display("FAIL fetch_stall: req=%b pc=%h rf_we=%b mem_req=%b, want req=1 pc=%h no strobes",
                 instr_req, pc, rf_we, mem_req, m_pc);
      end
      @(negedge clk);
    end
    instr_valid = 1'b1;
    instr_data = ins;
    mem_ready = 1'($urandom);
    #1;
    checks++;
    if (instr_req !== 1'b1 || pc !== m_pc || rf_we !== 1'b0 || mem_req !== 1'b0 || mux_select !== 2'b00) begin
      errors++;
      $display("FAIL fetch %h: req=%b pc=%h rf_we=%b mem_req=%b sel=%b, want req=1 pc=%h no strobes",
               ins, instr_req, pc, rf_we, mem_req, mux_select, m_pc);
    end
    @(negedge clk);
    instr_valid = 1'($urandom);
    instr_data = 16'($urandom);
    #1;
    checks++;
    if (instr_req !== 1'b0 || rf_we !== 1'b0 || mem_req !== 1'b0 || rf_waddr !== ins[11:10] ||
        rf_raddr !== ins[9:8] || imm_out !== ins[7:0]) begin
      errors++;
      $display("FAIL decode %h: req=%b rf_we=%b mem_req=%b waddr=%0d raddr=%0d imm=%h, want 0 0 0 %0d %0d %h",
               ins, instr_req, rf_we, mem_req, rf_waddr, rf_raddr, imm_out, ins[11:10], ins[9:8], ins[7:0]);
    end
    @(negedge clk);
    instr_valid = 1'($urandom);
    mem_ready = 1'($urandom);
    #1;
    checks++;
    if (rf_we !== (op == 4'h1 || op == 4'h3) || mux_select !== (op == 4'h3 ? 2'b10 : 2'b00) ||
        mem_req !== is_mem || mem_we !== (op == 4'h4) || instr_req !== 1'b0 || halted !== 1'b0 ||
        (is_mem && mem_addr !== ins[7:0])) begin
      errors++;
      $display("FAIL exec %h: rf_we=%b sel=%b mem_req=%b mem_we=%b addr=%h req=%b halted=%b, want rf_we=%b sel=%b mem_req=%b mem_we=%b addr=%h",
               ins, rf_we, mux_select, mem_req, mem_we, mem_addr, instr_req, halted,
               op == 4'h1 || op == 4'h3, op == 4'h3 ? 2'b10 : 2'b00, is_mem, op == 4'h4, ins[7:0]);
    end
    we_cnt += int'(rf_we);
    @(negedge clk);
    if (is_mem) begin
      for (int k = 0; k <= wait_n; k++) begin
        mem_ready = k == wait_n;
        instr_valid = 1'($urandom);
        #1;
        checks++;
        if (mem_req !== 1'b1 || mem_we !== (op == 4'h4) || mem_addr !== ins[7:0] || instr_req !== 1'b0 ||
            rf_we !== (op == 4'h2 && k == wait_n) || mux_select !== ((op == 4'h2 && k == wait_n) ? 2'b01 : 2'b00)) begin
          errors++;
          $display("FAIL mem_wait %h cyc %0d: mem_req=%b mem_we=%b addr=%h rf_we=%b sel=%b, want 1 %b %h %b %b",
                   ins, k, mem_req, mem_we, mem_addr, rf_we, mux_select, op == 4'h4, ins[7:0],
                   op == 4'h2 && k == wait_n, (op == 4'h2 && k == wait_n) ? 2'b01 : 2'b00);
        end
        we_cnt += int'(rf_we);
        @(negedge clk);
      end
      mem_ready = 1'b0;
    end
    if (ends_halt) begin
      for (int i = 0; i < 12; i++) begin
        instr_valid = 1'($urandom);
        mem_ready = 1'($urandom);
        #1;
        checks++;
        if (halted !== 1'b1 || illegal !== !legal || instr_req !== 1'b0 || rf_we !== 1'b0 || mem_req !== 1'b0) begin
          errors++;
          $display("FAIL halt %h: halted=%b illegal=%b req=%b rf_we=%b mem_req=%b, want halted=1 illegal=%b rest 0",
                   ins, halted, illegal, instr_req, rf_we, mem_req, !legal);
        end
        @(negedge clk);
      end
    end else begin
      checks++;
      if (we_cnt != exp_we_cnt) begin
        errors++;
        $display("FAIL rf_we_count %h: got %0d pulses, want %0d", ins, we_cnt, exp_we_cnt);
      end
      m_pc = op == 4'h5 ? ins[7:0] : m_pc + 8'd1;
    end
    instr_valid = 1'b0;
  endtask
  task automatic test_ldi();
    exec_instr(16'h325A, 0, 0);
  endtask
  task automatic test_ld_wait();
    exec_instr(16'h2440, 0, 3);
  endtask
  task automatic test_st_mov();
    exec_instr(16'h4310, 0, 2);
    exec_instr(16'h1030, 1, 0);
  endtask
  task automatic test_jmp_wrap();
    exec_instr(16'h50FF, 0, 0);
    exec_instr(16'h0000, 0, 0);
    #1;
    checks++;
    if (pc !== 8'h00 || instr_req !== 1'b1) begin
      errors++;
      $display("FAIL pc_wrap: pc=%h req=%b, want pc=00 req=1", pc, instr_req);
    end
    @(negedge clk);
  endtask
  task automatic test_fetch_stall();
    exec_instr(16'h0000, 5, 0);
  endtask
  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      logic [15:0] ins;
      ins = 16'($urandom);
      ins[15:12] = 4'($urandom_range(0, 5));
      exec_instr(ins, $urandom_range(0, 3), $urandom_range(0, 4));
    end
  endtask
  task automatic test_halt_illegal();
    exec_instr(16'h7000, 0, 0);
    test_reset();
    exec_instr({4'($urandom_range(6, 14)), 12'($urandom)}, 1, 0);
    test_reset();
    exec_instr(16'hF000, 0, 0);
    test_reset();
  endtask
  task automatic test_mid_reset();
    exec_instr(16'h0000, 0, 0);
    exec_instr(16'h0000, 0, 0);
    instr_valid = 1'b1;
    instr_data = 16'h2440;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (mem_req !== 1'b1 || pc !== 8'h02) begin
      errors++;
      $display("FAIL mid_reset_pre: mem_req=%b pc=%h, want mem_req=1 pc=02", mem_req, pc);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_pc = '0;
    #1;
    checks++;
    if (instr_req !== 1'b1 || pc !== 8'h00 || mem_req !== 1'b0 || rf_we !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: req=%b pc=%h mem_req=%b rf_we=%b, want req=1 pc=00 mem_req=0 rf_we=0",
               instr_req, pc, mem_req, rf_we);
    end
    @(negedge clk);
    exec_instr(16'h3A11, 0, 0);
  endtask
  initial begin
    test_reset();
    test_ldi();
    test_ld_wait();
    test_st_mov();
    test_jmp_wrap();
    test_fetch_stall();
    test_random();
    test_halt_illegal();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
